// File: rtl/wb_bank_arbiter.sv
// Two-port Wishbone arbiter for the dual-bank shared RAM.
// Per-bank round-robin, registered acks, saturating conflict counter.
module wb_bank_arbiter #(
  parameter int A_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pA_wb_stb_i,
  input  logic [A_WIDTH:0]     pA_wb_addr_i,
  input  logic                 pB_wb_stb_i,
  input  logic [A_WIDTH:0]     pB_wb_addr_i,
  output logic                 pA_wb_stall_o,
  output logic                 pB_wb_stall_o,
  output logic                 pA_wb_ack_o,
  output logic                 pB_wb_ack_o,
  output logic                 ram0_en_o,
  output logic                 ram0_sel_o,
  output logic                 ram1_en_o,
  output logic                 ram1_sel_o,
  output logic                 pA_rsel_o,
  output logic                 pB_rsel_o,
  output logic [CNT_WIDTH-1:0] conflict_cnt_o
);

  logic       bankA;
  logic       bankB;
  logic       conflict;
  logic       winB;
  logic       grantA;
  logic       grantB;
  logic       liveA;
  logic       liveB;
  logic [1:0] prio;

  // Bank decode and grant; flops use the raw grants,
  // reset only masks what leaves the block.
  always_comb begin
    bankA    = pA_wb_addr_i[A_WIDTH];
    bankB    = pB_wb_addr_i[A_WIDTH];
    conflict = pA_wb_stb_i & pB_wb_stb_i
             & (bankA == bankB);
    winB     = prio[bankA];
    grantA   = pA_wb_stb_i & ~(conflict & winB);
    grantB   = pB_wb_stb_i & ~(conflict & ~winB);
  end

  // RAM enables/selects and stalls, forced idle in reset.
  always_comb begin
    liveA         = rst & grantA;
    liveB         = rst & grantB;
    ram0_en_o     = (liveA & ~bankA) | (liveB & ~bankB);
    ram0_sel_o    = liveB & ~bankB;
    ram1_en_o     = (liveA & bankA) | (liveB & bankB);
    ram1_sel_o    = liveB & bankB;
    pA_wb_stall_o = ~rst | (pA_wb_stb_i & ~grantA);
    pB_wb_stall_o = ~rst | (pB_wb_stb_i & ~grantB);
  end

  // Round-robin: the loser of a conflict owns the bank next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 2'b00;
    end else if (conflict) begin
      prio[bankA] <= ~winB;
    end
  end

  // One-cycle acks; rsel follows the bank of the latest grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pA_wb_ack_o <= 1'b0;
      pB_wb_ack_o <= 1'b0;
      pA_rsel_o   <= 1'b0;
      pB_rsel_o   <= 1'b0;
    end else begin
      pA_wb_ack_o <= grantA;
      pB_wb_ack_o <= grantB;
      if (grantA) pA_rsel_o <= bankA;
      if (grantB) pB_rsel_o <= bankB;
    end
  end

  // Saturating count of conflict cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt_o <= '0;
    end else if (conflict && (conflict_cnt_o != '1)) begin
      conflict_cnt_o <= conflict_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_wb_bank_arbiter.sv
// Directed bench for wb_bank_arbiter.
// Second instance with CNT_WIDTH=2 covers counter saturation.
module tb_wb_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stbA = 1'b0;
  logic       stbB = 1'b0;
  logic [8:0] addrA = '0;
  logic [8:0] addrB = '0;

  logic        stallA, stallB, ackA, ackB;
  logic        en0, sel0, en1, sel1, rselA, rselB;
  logic [15:0] cnt;

  logic       sStallA, sStallB, sAckA, sAckB;
  logic       sEn0, sSel0, sEn1, sSel1, sRselA, sRselB;
  logic [1:0] sCnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_bank_arbiter #(.A_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .pA_wb_stb_i(stbA), .pA_wb_addr_i(addrA),
    .pB_wb_stb_i(stbB), .pB_wb_addr_i(addrB),
    .pA_wb_stall_o(stallA), .pB_wb_stall_o(stallB),
    .pA_wb_ack_o(ackA), .pB_wb_ack_o(ackB),
    .ram0_en_o(en0), .ram0_sel_o(sel0),
    .ram1_en_o(en1), .ram1_sel_o(sel1),
    .pA_rsel_o(rselA), .pB_rsel_o(rselB),
    .conflict_cnt_o(cnt)
  );

  wb_bank_arbiter #(.A_WIDTH(8), .CNT_WIDTH(2)) dutSmall (
    .clk(clk), .rst(rst),
    .pA_wb_stb_i(stbA), .pA_wb_addr_i(addrA),
    .pB_wb_stb_i(stbB), .pB_wb_addr_i(addrB),
    .pA_wb_stall_o(sStallA), .pB_wb_stall_o(sStallB),
    .pA_wb_ack_o(sAckA), .pB_wb_ack_o(sAckB),
    .ram0_en_o(sEn0), .ram0_sel_o(sSel0),
    .ram1_en_o(sEn1), .ram1_sel_o(sSel1),
    .pA_rsel_o(sRselA), .pB_rsel_o(sRselB),
    .conflict_cnt_o(sCnt)
  );

  task automatic doReset();
    rst = 1'b0;
    stbA = 1'b0;
    stbB = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stbA = 1'b1;
    stbB = 1'b1;
    addrA = 9'h000;
    addrB = 9'h000;
    @(posedge clk);
    #1;
    total++;
    if ({ackA, ackB, rselA, rselB} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_regs got=%b exp=0000",
               {ackA, ackB, rselA, rselB});
    end
    total++;
    if ({stallA, stallB, en0, sel0, en1, sel1} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_comb got=%b exp=110000",
               {stallA, stallB, en0, sel0, en1, sel1});
    end
    total++;
    if (cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d exp=0", cnt);
    end
    doReset();
  endtask

  task automatic test_split_banks();
    doReset();
    @(posedge clk);
    #1;
    stbA = 1'b1;
    addrA = 9'h000;
    stbB = 1'b1;
    addrB = 9'h100;
    #1;
    total++;
    if ({en0, en1, sel0, sel1, stallA, stallB} !== 6'b110100) begin
      bad++;
      $display("FAIL split_comb got=%b exp=110100",
               {en0, en1, sel0, sel1, stallA, stallB});
    end
    @(posedge clk);
    #1;
    stbA = 1'b0;
    stbB = 1'b0;
    total++;
    if ({ackA, ackB, rselA, rselB} !== 4'b1101) begin
      bad++;
      $display("FAIL split_ack got=%b exp=1101",
               {ackA, ackB, rselA, rselB});
    end
    total++;
    if (cnt !== 16'd0) begin
      bad++;
      $display("FAIL split_cnt got=%0d exp=0", cnt);
    end
    @(posedge clk);
    #1;
    total++;
    if ({ackA, ackB} !== 2'b00) begin
      bad++;
      $display("FAIL split_ack_once got=%b exp=00", {ackA, ackB});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] winner;
    winner = 4'b1010;
    doReset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        total++;
        if ({ackA, ackB} !== {~winner[i-1], winner[i-1]}) begin
          bad++;
          $display("FAIL rr_ack%0d got=%b exp=%b", i, {ackA, ackB},
                   {~winner[i-1], winner[i-1]});
        end
      end
      if (i < 4) begin
        stbA = 1'b1;
        stbB = 1'b1;
        addrA = 9'h103;
        addrB = 9'h103;
        #1;
        total++;
        if ({sel1, en1, stallA, stallB}
            !== {winner[i], 1'b1, winner[i], ~winner[i]}) begin
          bad++;
          $display("FAIL rr_grant%0d got=%b exp=%b", i,
                   {sel1, en1, stallA, stallB},
                   {winner[i], 1'b1, winner[i], ~winner[i]});
        end
      end else begin
        stbA = 1'b0;
        stbB = 1'b0;
      end
    end
    total++;
    if (cnt !== 16'd4) begin
      bad++;
      $display("FAIL rr_cnt got=%0d exp=4", cnt);
    end
  endtask

  task automatic test_solo_keeps_prio();
    doReset();
    @(posedge clk);
    #1;
    stbA = 1'b1;
    stbB = 1'b1;
    addrA = 9'h110;
    addrB = 9'h120;
    #1;
    total++;
    if ({sel1, stallB} !== 2'b01) begin
      bad++;
      $display("FAIL solo_first got=%b exp=01", {sel1, stallB});
    end
    @(posedge clk);
    #1;
    stbB = 1'b0;
    #1;
    total++;
    if ({en1, sel1, stallA} !== 3'b100) begin
      bad++;
      $display("FAIL solo_alone got=%b exp=100", {en1, sel1, stallA});
    end
    @(posedge clk);
    #1;
    stbB = 1'b1;
    #1;
    total++;
    if ({sel1, stallA, stallB} !== 3'b110) begin
      bad++;
      $display("FAIL solo_bwins got=%b exp=110",
               {sel1, stallA, stallB});
    end
    @(posedge clk);
    #1;
    addrA = 9'h001;
    addrB = 9'h002;
    #1;
    total++;
    if ({en0, sel0, stallA, stallB} !== 4'b1001) begin
      bad++;
      $display("FAIL solo_bank0 got=%b exp=1001",
               {en0, sel0, stallA, stallB});
    end
    @(posedge clk);
    #1;
    stbA = 1'b0;
    stbB = 1'b0;
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        total++;
        if ({ackA, ackB, rselB} !== 3'b010) begin
          bad++;
          $display("FAIL b2b_ack%0d got=%b exp=010", i,
                   {ackA, ackB, rselB});
        end
      end
      if (i < 3) begin
        stbB = 1'b1;
        addrB = 9'h005 + 9'(i);
        #1;
        total++;
        if ({stallB, en0, sel0, en1} !== 4'b0110) begin
          bad++;
          $display("FAIL b2b_grant%0d got=%b exp=0110", i,
                   {stallB, en0, sel0, en1});
        end
      end else begin
        stbB = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_conflict();
    doReset();
    @(posedge clk);
    #1;
    stbA = 1'b1;
    stbB = 1'b1;
    addrA = 9'h010;
    addrB = 9'h020;
    @(posedge clk);
    #1;
    total++;
    if (ackA !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_preack got=%b exp=1", ackA);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({ackA, ackB, stallA, stallB, en0, sel0} !== 6'b001100) begin
      bad++;
      $display("FAIL rstmid_async got=%b exp=001100",
               {ackA, ackB, stallA, stallB, en0, sel0});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if ({cnt, sel0, stallA, stallB} !== {16'd0, 3'b001}) begin
      bad++;
      $display("FAIL rstmid_release got=%0d/%b exp=0/001",
               cnt, {sel0, stallA, stallB});
    end
    @(posedge clk);
    #1;
    stbA = 1'b0;
    stbB = 1'b0;
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (sCnt !== 2'((i > 3) ? 3 : i)) begin
        bad++;
        $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, sCnt,
                 (i > 3) ? 3 : i);
      end
      if (i < 6) begin
        stbA = 1'b1;
        stbB = 1'b1;
        addrA = 9'h1F0;
        addrB = 9'h1F1;
      end else begin
        stbA = 1'b0;
        stbB = 1'b0;
      end
    end
    total++;
    if (cnt !== 16'd6) begin
      bad++;
      $display("FAIL sat_wide got=%0d exp=6", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_split_banks();
    test_round_robin();
    test_solo_keeps_prio();
    test_back_to_back();
    test_reset_mid_conflict();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
